rw_reg_bank: RTL and testbench
==============================

RW_REG_BANK -- requirements
Module: rw_reg_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits; legal values are multiples of 8 from 8 to 64.
REQ-002 SHALL have parameter NUM_REGS, default 8, number of registers; legal values are 2 to 64.
REQ-003 SHALL have parameter DEFAULT_VALUE, default all-zero, NUM_REGS*DATA_W reset image; register i occupies slice [i*DATA_W +: DATA_W].
REQ-004 SHALL have parameter W1C_MASK, default 0, NUM_REGS bits; bit i=1 makes register i write-1-to-clear.
REQ-005 SHALL have parameter RO_MASK, default 0, NUM_REGS bits; bit i=1 makes register i read-only; RO takes precedence over W1C.
REQ-006 SHALL have parameter BYPASS, default 1; 1 forwards write data onto reg_q in the accept cycle.
REQ-007 SHALL use localparam ADDR_W = max(1, clog2(NUM_REGS)).
REQ-008 SHALL have port clk_reg, input, 1 bit: the single clock, rising-edge active.
REQ-009 SHALL have port rst_reg, input, 1 bit: reset, synchronous and active-high.
REQ-010 SHALL have port req_valid, input, 1 bit: request present.
REQ-011 SHALL have port req_ready, output, 1 bit: request can be accepted.
REQ-012 SHALL have port req_wr, input, 1 bit: 1 = write, 0 = read.
REQ-013 SHALL have port req_addr, input, ADDR_W bits: register index.
REQ-014 SHALL have port req_wdata, input, DATA_W bits: write data.
REQ-015 SHALL have port req_wstrb, input, DATA_W/8 bits: byte enables.
REQ-016 SHALL have port rsp_valid, output, 1 bit: response present.
REQ-017 SHALL have port rsp_ready, input, 1 bit: response consumed.
REQ-018 SHALL have port rsp_rdata, output, DATA_W bits: read data; 0 for writes.
REQ-019 SHALL have port rsp_err, output, 1 bit: address out of range, or write to an RO register.
REQ-020 SHALL have port hw_set, input, NUM_REGS*DATA_W bits: per-bit set pulses for W1C registers; ignored for other registers.
REQ-021 SHALL have port hw_val, input, NUM_REGS*DATA_W bits: live value of RO registers.
REQ-022 SHALL have port reg_q, output, NUM_REGS*DATA_W bits: current value of every register.

Function
REQ-023 SHALL accept a request in a cycle where req_valid and req_ready are both 1 ("accept cycle").
REQ-024 SHALL drive req_ready = !rsp_valid || rsp_ready, combinationally; one outstanding response; back-to-back throughput is 1 per cycle while rsp_ready=1.
REQ-025 SHALL assert rsp_valid on the cycle after acceptance and hold rsp_valid, rsp_rdata and rsp_err stable until rsp_valid && rsp_ready.
REQ-026 SHALL, for an RW write, replace each byte k whose req_wstrb[k]=1 with req_wdata, at the accept-cycle edge.
REQ-027 SHALL, for a W1C write, clear each bit where the strobe is 1 and req_wdata=1; other bits are unchanged.
REQ-028 SHALL set W1C register bits where hw_set=1 every cycle; a coincident set and clear on the same bit results in 1.
REQ-029 SHALL, for RO registers, return hw_val on reg_q and on reads; a write changes nothing and returns rsp_err=1.
REQ-030 SHALL, for a read, return the register value as it was at the accept cycle, before any coincident hw_set.
REQ-031 SHALL treat req_addr >= NUM_REGS as out of range: no state change, rsp_rdata=0, rsp_err=1.
REQ-032 SHALL, with BYPASS=1, drive reg_q for the target RW/W1C register with its post-write value combinationally in the accept cycle; with BYPASS=0, reg_q is purely registered.
REQ-033 SHALL treat a write with req_wstrb=0 as legal: no change, rsp_err=0.

Reset
REQ-034 SHALL, on a clock edge with rst_reg=1, load DEFAULT_VALUE into all RW/W1C registers and clear rsp_valid, rsp_rdata and rsp_err to 0.
REQ-035 SHALL hold req_ready=1 and ignore hw_set while rst_reg=1; a pending response is discarded.

Verification (DATA_W=32, NUM_REGS=4, W1C_MASK=4'b0100, RO_MASK=4'b1000, DEFAULT_VALUE reg1=0x0000_00A5)
REQ-036 SHALL check reset: after reset, a read of reg1 gives rsp_rdata=0x0000_00A5 and rsp_err=0; rsp_valid was 0 during reset.
REQ-037 SHALL check byte-strobe write: write reg0 with 0xDEADBEEF, wstrb=4'b0101, then read reg0 -> 0x00AD00EF; reg_q[31:0] shows 0x00AD00EF in the accept cycle (BYPASS=1).
REQ-038 SHALL check W1C: hw_set reg2=0xF0, then write 0x30 with wstrb=4'hF -> read gives 0xC0; same-cycle set 0x10 and clear 0x10 -> bit 4 reads 1.
REQ-039 SHALL check RO and out-of-range: hw_val reg3=0x1234 -> read gives 0x1234, err=0; write reg3 -> err=1 and value unchanged.
REQ-040 SHALL check backpressure: hold rsp_ready=0 for 3 cycles -> req_ready=0 and the response is held stable; release gives 1 request per cycle.
REQ-041 SHALL check reset mid-operation: assert rst_reg while rsp_valid=1 -> rsp_valid=0 next cycle and all registers return to DEFAULT_VALUE.

Source files
------------

// File: rtl/rw_reg_bank.sv
// rtl/rw_reg_bank.sv - parameterised register bank with RW, W1C and RO registers behind a valid/ready request/response port
// Holds one outstanding response; reads return the pre-update value and writes apply at the accept-cycle edge.
module rw_reg_bank #(
    parameter int                          DATA_W        = 32,
    parameter int                          NUM_REGS      = 8,
    parameter logic [NUM_REGS*DATA_W-1:0]  DEFAULT_VALUE = '0,
    parameter logic [NUM_REGS-1:0]         W1C_MASK      = '0,
    parameter logic [NUM_REGS-1:0]         RO_MASK       = '0,
    parameter bit                          BYPASS        = 1'b1,
    localparam int                         ADDR_W        = ($clog2(NUM_REGS) > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                          clk_reg,
    input  logic                          rst_reg,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_wr,
    input  logic [ADDR_W-1:0]             req_addr,
    input  logic [DATA_W-1:0]             req_wdata,
    input  logic [DATA_W/8-1:0]           req_wstrb,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_W-1:0]             rsp_rdata,
    output logic                          rsp_err,
    input  logic [NUM_REGS*DATA_W-1:0]    hw_set,
    input  logic [NUM_REGS*DATA_W-1:0]    hw_val,
    output logic [NUM_REGS*DATA_W-1:0]    reg_q
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] regs_q  [NUM_REGS];
    logic [DATA_W-1:0] regs_d  [NUM_REGS];
    logic [DATA_W-1:0] wr_val  [NUM_REGS];
    logic [DATA_W-1:0] set_a   [NUM_REGS];
    logic [DATA_W-1:0] val_a   [NUM_REGS];
    logic [NUM_REGS-1:0] wr_sel;

    logic              accept;
    logic              in_range;
    logic              ro_hit;
    logic [DATA_W-1:0] strb_mask;
    logic [DATA_W-1:0] rd_val;

    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [DATA_W-1:0] rsp_rdata_q;

    // Reset keeps the port open so a stalled response cannot block the bus across reset.
    assign req_ready = rst_reg || !rsp_valid_q || rsp_ready;
    assign accept    = req_valid && req_ready;
    assign in_range  = 32'(req_addr) < NUM_REGS;

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    always_comb begin
        strb_mask = '0;
        for (int k = 0; k < NB; k++) begin
            strb_mask[k*8 +: 8] = {8{req_wstrb[k]}};
        end
    end

    always_comb begin
        rd_val = '0;
        ro_hit = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            set_a[i] = hw_set[i*DATA_W +: DATA_W];
            val_a[i] = hw_val[i*DATA_W +: DATA_W];
        end
        if (in_range) begin
            ro_hit = RO_MASK[req_addr];
            rd_val = RO_MASK[req_addr] ? val_a[req_addr] : regs_q[req_addr];
        end
    end

    always_comb begin
        reg_q = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_sel[i] = accept && !rst_reg && req_wr && in_range && (req_addr == ADDR_W'(i));
            wr_val[i] = regs_q[i];
            if (wr_sel[i] && !RO_MASK[i]) begin
                if (W1C_MASK[i]) begin
                    wr_val[i] = regs_q[i] & ~(req_wdata & strb_mask);
                end else begin
                    wr_val[i] = (regs_q[i] & ~strb_mask) | (req_wdata & strb_mask);
                end
            end
            // hw_set is OR-ed after the clear so a coincident set wins.
            regs_d[i] = wr_val[i];
            if (W1C_MASK[i] && !RO_MASK[i]) begin
                regs_d[i] = wr_val[i] | set_a[i];
            end
            if (RO_MASK[i]) begin
                reg_q[i*DATA_W +: DATA_W] = val_a[i];
            end else if (BYPASS) begin
                reg_q[i*DATA_W +: DATA_W] = wr_val[i];
            end else begin
                reg_q[i*DATA_W +: DATA_W] = regs_q[i];
            end
        end
    end

    always_ff @(posedge clk_reg) begin
        if (rst_reg) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= DEFAULT_VALUE[i*DATA_W +: DATA_W];
            end
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            if (accept) begin
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= req_wr ? '0 : rd_val;
                rsp_err_q   <= !in_range || (req_wr && ro_hit);
            end else if (rsp_ready) begin
                rsp_valid_q <= 1'b0;
                rsp_rdata_q <= '0;
                rsp_err_q   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rw_reg_bank.sv
// tb/tb_rw_reg_bank.sv - directed self-checking bench for rw_reg_bank
module tb_rw_reg_bank;

    localparam int DW = 32;
    localparam int NR = 4;

    logic           clk_reg = 1'b0;
    logic           rst_reg;
    logic           req_valid;
    logic           req_ready;
    logic           req_wr;
    logic [1:0]     req_addr;
    logic [31:0]    req_wdata;
    logic [3:0]     req_wstrb;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [31:0]    rsp_rdata;
    logic           rsp_err;
    logic [127:0]   hw_set;
    logic [127:0]   hw_val;
    logic [127:0]   reg_q;

    int checks = 0;
    int errors = 0;

    logic [31:0] rd;
    logic        er;

    always #5 clk_reg = ~clk_reg;

    rw_reg_bank #(
        .DATA_W        (DW),
        .NUM_REGS      (NR),
        .DEFAULT_VALUE ({32'h0, 32'h0, 32'h0000_00A5, 32'h0}),
        .W1C_MASK      (4'b0100),
        .RO_MASK       (4'b1000),
        .BYPASS        (1'b1)
    ) dut (
        .clk_reg   (clk_reg),
        .rst_reg   (rst_reg),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .hw_set    (hw_set),
        .hw_val    (hw_val),
        .reg_q     (reg_q)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_reg);
        #1;
    endtask

    // One request with rsp_ready=1; returns the response seen the cycle after acceptance.
    task automatic xfer(input logic wr, input logic [1:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, output logic [31:0] r, output logic e);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = a;
        req_wdata = wd;
        req_wstrb = ws;
        #1;
        chk("xfer_req_ready", 128'(req_ready), 128'(1'b1));
        step();
        req_valid = 1'b0;
        chk("xfer_rsp_valid", 128'(rsp_valid), 128'(1'b1));
        r = rsp_rdata;
        e = rsp_err;
    endtask

    initial begin
        rst_reg   = 1'b1;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        rsp_ready = 1'b0;
        hw_set    = '0;
        hw_val    = '0;

        // reset: port ready, no response
        step();
        step();
        chk("rst_rsp_valid", 128'(rsp_valid), 128'(1'b0));
        chk("rst_req_ready", 128'(req_ready), 128'(1'b1));
        rst_reg   = 1'b0;
        rsp_ready = 1'b1;
        step();

        xfer(1'b0, 2'd1, 32'h0, 4'h0, rd, er);
        chk("rst_read_reg1", 128'(rd), 128'h0000_00A5);
        chk("rst_read_err", 128'(er), 128'(1'b0));

        // byte-strobe write with bypass visible in the accept cycle
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 2'd0;
        req_wdata = 32'hDEAD_BEEF; req_wstrb = 4'b0101;
        #1;
        chk("bypass_reg0", 128'(reg_q[31:0]), 128'h00AD_00EF);
        step();
        req_valid = 1'b0;
        chk("wr_rsp_err", 128'(rsp_err), 128'(1'b0));
        chk("wr_rsp_rdata", 128'(rsp_rdata), 128'h0);
        xfer(1'b0, 2'd0, 32'h0, 4'h0, rd, er);
        chk("strb_read_reg0", 128'(rd), 128'h00AD_00EF);

        // W1C: hardware set then software clear
        hw_set[95:64] = 32'hF0;
        step();
        hw_set = '0;
        chk("w1c_set_regq", 128'(reg_q[95:64]), 128'hF0);
        xfer(1'b1, 2'd2, 32'h30, 4'hF, rd, er);
        xfer(1'b0, 2'd2, 32'h0, 4'h0, rd, er);
        chk("w1c_clear", 128'(rd), 128'hC0);
        hw_set[95:64] = 32'h10;
        xfer(1'b1, 2'd2, 32'h10, 4'hF, rd, er);
        hw_set = '0;
        xfer(1'b0, 2'd2, 32'h0, 4'h0, rd, er);
        chk("w1c_set_wins", 128'(rd), 128'hD0);

        // RO register
        hw_val[127:96] = 32'h1234;
        xfer(1'b0, 2'd3, 32'h0, 4'h0, rd, er);
        chk("ro_read", 128'(rd), 128'h1234);
        chk("ro_read_err", 128'(er), 128'(1'b0));
        xfer(1'b1, 2'd3, 32'hFFFF_FFFF, 4'hF, rd, er);
        chk("ro_write_err", 128'(er), 128'(1'b1));
        xfer(1'b0, 2'd3, 32'h0, 4'h0, rd, er);
        chk("ro_unchanged", 128'(rd), 128'h1234);

        // zero-strobe write is legal and inert
        xfer(1'b1, 2'd0, 32'h5555_5555, 4'h0, rd, er);
        chk("zero_strb_err", 128'(er), 128'(1'b0));
        xfer(1'b0, 2'd0, 32'h0, 4'h0, rd, er);
        chk("zero_strb_val", 128'(rd), 128'h00AD_00EF);

        // backpressure: response held while rsp_ready=0, next request waits
        step();
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 2'd1;
        step();
        req_addr = 2'd0;
        for (int c = 0; c < 3; c++) begin
            chk("bp_req_ready", 128'(req_ready), 128'(1'b0));
            chk("bp_rsp_valid", 128'(rsp_valid), 128'(1'b1));
            chk("bp_rsp_rdata", 128'(rsp_rdata), 128'h0000_00A5);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", 128'(req_ready), 128'(1'b1));
        step();
        chk("b2b_rsp0", 128'(rsp_rdata), 128'h00AD_00EF);
        req_addr = 2'd1;
        step();
        chk("b2b_rsp1", 128'(rsp_rdata), 128'h0000_00A5);
        req_addr = 2'd2;
        step();
        chk("b2b_rsp2", 128'(rsp_rdata), 128'hD0);
        chk("b2b_valid", 128'(rsp_valid), 128'(1'b1));
        req_valid = 1'b0;
        step();
        chk("b2b_drain", 128'(rsp_valid), 128'(1'b0));

        // reset with a response pending
        rsp_ready = 1'b0;
        xfer(1'b0, 2'd2, 32'h0, 4'h0, rd, er);
        rst_reg = 1'b1;
        step();
        chk("midrst_rsp_valid", 128'(rsp_valid), 128'(1'b0));
        chk("midrst_rsp_rdata", 128'(rsp_rdata), 128'h0);
        chk("midrst_regq", reg_q, {32'h1234, 32'h0, 32'h0000_00A5, 32'h0});
        rst_reg   = 1'b0;
        rsp_ready = 1'b1;
        step();
        xfer(1'b0, 2'd0, 32'h0, 4'h0, rd, er);
        chk("midrst_read_reg0", 128'(rd), 128'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
